// File: rtl/exec_ctrl_md_pkg.sv
// exec_pkg: ALU codes, funct fields, ALU_op encodings and mult/div sequencer states
package exec_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100, ALU_SRA = 4'b0101, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111,
        ALU_SLLV = 4'b1000, ALU_SRLV = 4'b1001, ALU_SRAV = 4'b1010, ALU_ADDU = 4'b1011,
        ALU_NOR = 4'b1100, ALU_XOR = 4'b1101, ALU_SUBU = 4'b1110, ALU_SLTU = 4'b1111;
    localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011,
        F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111,
        F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011,
        F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011,
        F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011,
        F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111,
        F_SLT = 6'b101010, F_SLTU = 6'b101011;
    typedef enum logic [1:0] {AOP_MEM = 2'b00, AOP_BR = 2'b01, AOP_R = 2'b10, AOP_RSV = 2'b11} alu_op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_e;
endpackage

// File: rtl/exec_ctrl_md_if.sv
// exec_ctrl_md_if: EX-stage control bundle between the pipeline (master) and exec_ctrl_md (slave)
interface exec_ctrl_md_if #(parameter int DATA_W = 32);
    logic              valid_in, flush, md_sel, stall, div0, illegal;
    logic [5:0]        funct;
    logic [1:0]        ALU_op;
    logic [3:0]        ALU_ctrl;
    logic [DATA_W-1:0] rs_val, rt_val, md_result, hi, lo;
    modport master (output valid_in, flush, funct, ALU_op, rs_val, rt_val,
                    input ALU_ctrl, md_sel, md_result, stall, div0, illegal, hi, lo);
    modport slave (input valid_in, flush, funct, ALU_op, rs_val, rt_val,
                   output ALU_ctrl, md_sel, md_result, stall, div0, illegal, hi, lo);
endinterface

// File: rtl/exec_ctrl_md_muldiv_seq.sv
// muldiv_seq: radix-2 iterative multiply / restoring divide on magnitudes with a final sign fix.
// The divide path only exists when DIV_EN is set (driven from EXEC_DIV_EN by the top).
module muldiv_seq import exec_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int CNT_W = $clog2(DATA_W) + 1,
    parameter bit DIV_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              sgn_i,
    input  logic              div_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              div0_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int W = DATA_W;
    md_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opd_q, opd_d;
    logic neg_p_q, neg_p_d, neg_r_q, neg_r_d, div_q, div_d;
    logic sa, sb, dv, ge;
    logic [W-1:0] mag_a, mag_b, diff;
    logic [W:0] sum, r_sh;
    logic [2*W-1:0] prod;
    assign dv = DIV_EN && div_i;
    assign sa = sgn_i & a_i[W-1];
    assign sb = sgn_i & b_i[W-1];
    assign mag_a = sa ? -a_i : a_i;
    assign mag_b = sb ? -b_i : b_i;
    // multiply keeps {acc_hi, acc_lo} as product:multiplier; divide keeps remainder:quotient
    assign sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    assign r_sh = {acc_hi_q, acc_lo_q[W-1]};
    assign ge = r_sh >= {1'b0, opd_q};
    assign diff = r_sh[W-1:0] - opd_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opd_d = opd_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        div_d = div_q;
        if (flush_i) state_d = S_IDLE;
        else case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_RUN;
                cnt_d = CNT_W'(W);
                acc_hi_d = '0;
                acc_lo_d = dv ? mag_a : mag_b;
                opd_d = dv ? mag_b : mag_a;
                neg_p_d = sa ^ sb;
                neg_r_d = sa;
                div_d = dv;
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                state_d = cnt_q == CNT_W'(1) ? S_FIX : S_RUN;
                {acc_hi_d, acc_lo_d} = div_q ? {ge ? diff : r_sh[W-1:0], acc_lo_q[W-2:0], ge}
                                             : {sum, acc_lo_q[W-1:1]};
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opd_q <= '0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
            div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opd_q <= opd_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
            div_q <= div_d;
        end
    end
    assign busy_o = state_q != S_IDLE;
    assign done_o = state_q == S_FIX && !flush_i;
    assign div0_o = done_o && div_q && opd_q == '0;
    assign prod = neg_p_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    // divide by zero: quotient forced to all ones, remainder sign fix restores the raw dividend
    assign hi_o = div_q ? (neg_r_q ? -acc_hi_q : acc_hi_q) : prod[2*W-1:W];
    assign lo_o = div_q ? (opd_q == '0 ? '1 : neg_p_q ? -acc_lo_q : acc_lo_q) : prod[W-1:0];
endmodule

// File: rtl/exec_ctrl_md.sv
// exec_ctrl_md: EX-stage ALU decode, HI/LO ownership, move instructions and mult/div stall.
// Define EXEC_DIV_EN to build the DIV/DIVU datapath; otherwise they decode as illegal.
module exec_ctrl_md import exec_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int CNT_W = $clog2(DATA_W) + 1
) (
    input logic clk,
    input logic reset,
    exec_ctrl_md_if.slave bus
);
`ifdef EXEC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, seq_hi, seq_lo;
    logic illegal_q, illegal_d, busy, done, div0, is_r, is_mul, is_div, start, mt_ok, r_known;
    logic [3:0] r_code;
    assign is_r = bus.ALU_op == AOP_R;
    assign is_mul = bus.funct inside {F_MULT, F_MULTU};
    assign is_div = bus.funct inside {F_DIV, F_DIVU};
    assign start = !busy && bus.valid_in && !bus.flush && is_r && (is_mul || (DIV_EN && is_div));
    assign mt_ok = !busy && bus.valid_in && is_r;
    always_comb begin
        r_code = ALU_ADD;
        r_known = 1'b1;
        case (bus.funct)
            F_ADD, F_MULT, F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO: r_code = ALU_ADD;
            F_ADDU: r_code = ALU_ADDU;
            F_SUB:  r_code = ALU_SUB;
            F_SUBU: r_code = ALU_SUBU;
            F_AND:  r_code = ALU_AND;
            F_OR:   r_code = ALU_OR;
            F_XOR:  r_code = ALU_XOR;
            F_NOR:  r_code = ALU_NOR;
            F_SLT:  r_code = ALU_SLT;
            F_SLTU: r_code = ALU_SLTU;
            F_SLL:  r_code = ALU_SLL;
            F_SRL:  r_code = ALU_SRL;
            F_SRA:  r_code = ALU_SRA;
            F_SLLV: r_code = ALU_SLLV;
            F_SRLV: r_code = ALU_SRLV;
            F_SRAV: r_code = ALU_SRAV;
            F_DIV, F_DIVU: r_known = DIV_EN;
            default: r_known = 1'b0;
        endcase
    end
    always_comb begin
        illegal_d = bus.valid_in && is_r && !r_known;
        hi_d = done ? seq_hi : mt_ok && bus.funct == F_MTHI ? bus.rs_val : hi_q;
        lo_d = done ? seq_lo : mt_ok && bus.funct == F_MTLO ? bus.rs_val : lo_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            illegal_q <= illegal_d;
        end
    end
    muldiv_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DIV_EN(DIV_EN)) u_seq (
        .clk(clk), .rst(reset), .start_i(start), .flush_i(bus.flush),
        .sgn_i(!bus.funct[0]), .div_i(bus.funct[1]), .a_i(bus.rs_val), .b_i(bus.rt_val),
        .busy_o(busy), .done_o(done), .div0_o(div0), .hi_o(seq_hi), .lo_o(seq_lo)
    );
    assign bus.ALU_ctrl = bus.ALU_op == AOP_BR ? ALU_SUB : is_r ? r_code : ALU_ADD;
    assign bus.md_sel = is_r && bus.funct inside {F_MFHI, F_MFLO};
    assign bus.md_result = !bus.md_sel ? '0 : bus.funct[1] ? lo_q : hi_q;
    assign bus.stall = busy || start;
    assign bus.div0 = div0;
    assign bus.illegal = illegal_q;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule
